adc_idelay_calib: RTL and testbench

Per-lane IDELAY calibration controller for the 8-lane DDR ADC input path (IBUFDS → IODELAYE1 → IDDR). It runs in the `adc_dco_clk` domain. On `start`, it sweeps every tap of each lane's IODELAYE1, which is configured as VAR_LOADABLE. At each tap it checks the IDDR rising and falling outputs against the ADC training pattern, then loads the center of the longest passing window. It replaces the current fixed `IDELAY_VALUE(0)` setup and reports per-lane failure.

---
 rtl/adc_if_pkg.sv | 20 ++
 rtl/adc_lane_window_tracker.sv | 67 ++++++
 rtl/adc_idelay_calib.sv | 166 ++++++++++++++++
 tb/tb_adc_idelay_calib.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_if_pkg.sv
// rtl/adc_if_pkg.sv - shared constants and FSM state type for the ADC input-path IDELAY calibration
package adc_if_pkg;

   localparam int         NUM_LANES = 8;
   localparam int         TAP_W     = 5;
   localparam logic [7:0] PATTERN_P = 8'hAA;
   localparam logic [7:0] PATTERN_N = 8'h55;

   typedef enum logic [2:0] {
      CS_IDLE,
      CS_LOAD,
      CS_SETTLE,
      CS_SAMPLE,
      CS_EVAL,
      CS_SET_FINAL,
      CS_NEXT_LANE,
      CS_DONE
   } calib_state_t;

endpackage

// File: rtl/adc_lane_window_tracker.sv
// rtl/adc_lane_window_tracker.sv - longest passing-tap run tracker and window centre for one lane sweep
module adc_lane_window_tracker
   import adc_if_pkg::*;
#(
   parameter int TAP_W = adc_if_pkg::TAP_W
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             clear_i,
   input  logic             eval_i,
   input  logic             pass_i,
   input  logic [TAP_W-1:0] tap_i,
   output logic [TAP_W-1:0] center_o,
   output logic             no_pass_o
);

   logic [TAP_W-1:0] cur_start_q, cur_start_d;
   logic [TAP_W:0]   cur_len_q, cur_len_d;
   logic [TAP_W-1:0] best_start_q, best_start_d;
   logic [TAP_W:0]   best_len_q, best_len_d;

   // Best is compared against the already-updated run so a run ending on the last tap counts.
   always_comb begin
      cur_start_d  = cur_start_q;
      cur_len_d    = cur_len_q;
      best_start_d = best_start_q;
      best_len_d   = best_len_q;
      if (clear_i) begin
         cur_start_d  = '0;
         cur_len_d    = '0;
         best_start_d = '0;
         best_len_d   = '0;
      end else if (eval_i) begin
         if (pass_i) begin
            if (cur_len_q == '0) begin
               cur_start_d = tap_i;
            end
            cur_len_d = cur_len_q + (TAP_W+1)'(1);
         end else begin
            cur_len_d = '0;
         end
         if (cur_len_d > best_len_q) begin
            best_start_d = cur_start_d;
            best_len_d   = cur_len_d;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cur_start_q  <= '0;
         cur_len_q    <= '0;
         best_start_q <= '0;
         best_len_q   <= '0;
      end else begin
         cur_start_q  <= cur_start_d;
         cur_len_q    <= cur_len_d;
         best_start_q <= best_start_d;
         best_len_q   <= best_len_d;
      end
   end

   // Centre uses the post-EVAL best so the final load can be registered on the EVAL edge.
   assign center_o  = best_start_d + best_len_d[TAP_W:1];
   assign no_pass_o = (best_len_d == '0);

endmodule

// File: rtl/adc_idelay_calib.sv
// rtl/adc_idelay_calib.sv - per-lane IODELAYE1 tap sweep against the ADC training pattern
module adc_idelay_calib #(
   parameter int                   NUM_LANES     = adc_if_pkg::NUM_LANES,
   parameter int                   TAP_W         = adc_if_pkg::TAP_W,
   parameter int                   SETTLE_CYCLES = 16,
   parameter int                   SAMPLE_CYCLES = 64,
   parameter logic [NUM_LANES-1:0] PATTERN_P     = NUM_LANES'(adc_if_pkg::PATTERN_P),
   parameter logic [NUM_LANES-1:0] PATTERN_N     = NUM_LANES'(adc_if_pkg::PATTERN_N)
) (
   input  logic                       adc_dco_clk,
   input  logic                       reset_n,
   input  logic                       start,
   input  logic [NUM_LANES-1:0]       data_p,
   input  logic [NUM_LANES-1:0]       data_n,
   output logic [NUM_LANES-1:0]       delay_ld,
   output logic [TAP_W-1:0]           delay_wdata,
   output logic                       busy,
   output logic                       done,
   output logic [NUM_LANES-1:0]       fail,
   output logic [NUM_LANES*TAP_W-1:0] lane_tap
);
   import adc_if_pkg::*;

   localparam int LANE_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [TAP_W-1:0]  TAP_LAST    = '1;
   localparam logic [LANE_W-1:0] LANE_LAST   = LANE_W'(NUM_LANES - 1);
   localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);

   calib_state_t               state_q;
   logic [LANE_W-1:0]          lane_q;
   logic [TAP_W-1:0]           tap_q;
   logic [CNT_W-1:0]           cnt_q;
   logic                       pass_q;
   logic [NUM_LANES-1:0]       delay_ld_q;
   logic [TAP_W-1:0]           delay_wdata_q;
   logic                       busy_q;
   logic                       done_q;
   logic [NUM_LANES-1:0]       fail_q;
   logic [NUM_LANES*TAP_W-1:0] lane_tap_q;

   logic             start_acc;
   logic             sample_bad;
   logic             trk_clear;
   logic             trk_eval;
   logic [TAP_W-1:0] trk_center;
   logic             trk_no_pass;

   function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [LANE_W-1:0] l);
      return NUM_LANES'(1) << l;
   endfunction

   assign start_acc  = start && ((state_q == CS_IDLE) || (state_q == CS_DONE));
   assign sample_bad = (data_p[lane_q] != PATTERN_P[lane_q]) ||
                       (data_n[lane_q] != PATTERN_N[lane_q]);
   assign trk_clear  = start_acc || (state_q == CS_NEXT_LANE);
   assign trk_eval   = (state_q == CS_EVAL);

   adc_lane_window_tracker #(
      .TAP_W (TAP_W)
   ) u_tracker (
      .clk_i     (adc_dco_clk),
      .rst_n_i   (reset_n),
      .clear_i   (trk_clear),
      .eval_i    (trk_eval),
      .pass_i    (pass_q),
      .tap_i     (tap_q),
      .center_o  (trk_center),
      .no_pass_o (trk_no_pass)
   );

   // Strobes are registered on the edge entering LOAD/SET_FINAL so they sit exactly in that state.
   always_ff @(posedge adc_dco_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= CS_IDLE;
         lane_q        <= '0;
         tap_q         <= '0;
         cnt_q         <= '0;
         pass_q        <= 1'b0;
         delay_ld_q    <= '0;
         delay_wdata_q <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         fail_q        <= '0;
         lane_tap_q    <= '0;
      end else begin
         delay_ld_q <= '0;
         case (state_q)
            CS_IDLE, CS_DONE: begin
               if (start) begin
                  state_q       <= CS_LOAD;
                  lane_q        <= '0;
                  tap_q         <= '0;
                  busy_q        <= 1'b1;
                  done_q        <= 1'b0;
                  delay_ld_q    <= lane_onehot('0);
                  delay_wdata_q <= '0;
               end
            end
            CS_LOAD: begin
               cnt_q   <= '0;
               pass_q  <= 1'b1;
               state_q <= CS_SETTLE;
            end
            CS_SETTLE: begin
               if (cnt_q == SETTLE_LAST) begin
                  cnt_q   <= '0;
                  state_q <= CS_SAMPLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            CS_SAMPLE: begin
               if (sample_bad) begin
                  pass_q <= 1'b0;
               end
               if (cnt_q == SAMPLE_LAST) begin
                  state_q <= CS_EVAL;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            CS_EVAL: begin
               delay_ld_q <= lane_onehot(lane_q);
               if (tap_q != TAP_LAST) begin
                  tap_q         <= tap_q + TAP_W'(1);
                  delay_wdata_q <= tap_q + TAP_W'(1);
                  state_q       <= CS_LOAD;
               end else begin
                  delay_wdata_q                      <= trk_center;
                  lane_tap_q[lane_q*TAP_W +: TAP_W] <= trk_center;
                  fail_q[lane_q]                     <= trk_no_pass;
                  state_q                            <= CS_SET_FINAL;
               end
            end
            CS_SET_FINAL: begin
               state_q <= CS_NEXT_LANE;
            end
            CS_NEXT_LANE: begin
               if (lane_q != LANE_LAST) begin
                  lane_q        <= lane_q + LANE_W'(1);
                  tap_q         <= '0;
                  delay_ld_q    <= lane_onehot(lane_q + LANE_W'(1));
                  delay_wdata_q <= '0;
                  state_q       <= CS_LOAD;
               end else begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= CS_DONE;
               end
            end
            default: state_q <= CS_IDLE;
         endcase
      end
   end

   assign delay_ld    = delay_ld_q;
   assign delay_wdata = delay_wdata_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign fail        = fail_q;
   assign lane_tap    = lane_tap_q;

endmodule

// File: tb/tb_adc_idelay_calib.sv
// tb/tb_adc_idelay_calib.sv - randomized sweep bench with a schedule/window reference model
module tb_adc_idelay_calib;

   localparam int NL       = 8;
   localparam int TW       = 5;
   localparam int SETTLE   = 16;
   localparam int SAMPLE   = 64;
   localparam int TAP_CYC  = SETTLE + SAMPLE + 2;
   localparam int LANE_CYC = 32 * TAP_CYC + 2;
   localparam int TOTAL    = NL * LANE_CYC;

   logic             clk;
   logic             reset_n;
   logic             start;
   logic [NL-1:0]    data_p, data_n;
   logic [NL-1:0]    delay_ld;
   logic [TW-1:0]    delay_wdata;
   logic             busy, done;
   logic [NL-1:0]    fail;
   logic [NL*TW-1:0] lane_tap;

   adc_idelay_calib dut (
      .adc_dco_clk (clk),
      .reset_n     (reset_n),
      .start       (start),
      .data_p      (data_p),
      .data_n      (data_n),
      .delay_ld    (delay_ld),
      .delay_wdata (delay_wdata),
      .busy        (busy),
      .done        (done),
      .fail        (fail),
      .lane_tap    (lane_tap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int            vectors     = 0;
   int            miscompares = 0;
   logic [31:0]   mask [NL];
   logic [TW-1:0] last_wd2 = '0;

   bit            m_active;
   bit            m_done;
   int            m_t;
   logic [NL-1:0] exp_fail;
   logic [TW-1:0] exp_tap [NL];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Longest all-pass window found by trying lengths from longest down, earliest start first.
   function automatic int ref_best(input logic [31:0] m);
      bit ok;
      for (int len = 32; len >= 1; len--) begin
         for (int s = 0; s + len <= 32; s++) begin
            ok = 1'b1;
            for (int k = 0; k < len; k++) if (!m[s+k]) ok = 1'b0;
            if (ok) return s + len / 2;
         end
      end
      return -1;
   endfunction

   function automatic logic [TW-1:0] ref_tap(input logic [31:0] m);
      int b;
      b = ref_best(m);
      return (b < 0) ? '0 : TW'(b);
   endfunction

   // Schedule model: m_t counts clock edges since the accepted start.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_active <= 1'b0;
         m_done   <= 1'b0;
         m_t      <= 0;
         exp_fail <= '0;
         for (int l = 0; l < NL; l++) exp_tap[l] <= '0;
      end else if (m_active) begin
         if ((m_t + 1) % LANE_CYC == LANE_CYC - 2) begin
            exp_fail[(m_t + 1) / LANE_CYC] <= (ref_best(mask[(m_t + 1) / LANE_CYC]) < 0);
            exp_tap[(m_t + 1) / LANE_CYC]  <= ref_tap(mask[(m_t + 1) / LANE_CYC]);
         end
         if (m_t + 1 == TOTAL) begin
            m_active <= 1'b0;
            m_done   <= 1'b1;
         end
         m_t <= m_t + 1;
      end else if (start) begin
         m_active <= 1'b1;
         m_done   <= 1'b0;
         m_t      <= 0;
      end
   end

   task automatic check_cycle();
      logic [NL-1:0]    eld;
      logic [TW-1:0]    ewd;
      logic [NL*TW-1:0] etap;
      int               lane, r;
      eld = '0;
      ewd = '0;
      if (m_active) begin
         lane = m_t / LANE_CYC;
         r    = m_t % LANE_CYC;
         if (r < LANE_CYC - 2 && r % TAP_CYC == 0) begin
            eld = NL'(1) << lane;
            ewd = TW'(r / TAP_CYC);
         end else if (r == LANE_CYC - 2) begin
            eld = NL'(1) << lane;
            ewd = ref_tap(mask[lane]);
         end
      end
      for (int l = 0; l < NL; l++) etap[l*TW +: TW] = exp_tap[l];
      chk("busy", busy, m_active);
      chk("done", done, m_done);
      chk("delay_ld", delay_ld, eld);
      if (eld != '0 || !reset_n) chk("delay_wdata", delay_wdata, ewd);
      chk("fail", fail, exp_fail);
      chk("lane_tap", lane_tap, etap);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         check_cycle();
      end
   end

   // IODELAY/ADC stand-in: data is random except in the sample window after a load of this lane.
   initial begin
      int            offs = 1000;
      int            ldl  = 0;
      int            ldt  = 0;
      int            goff = 0;
      int            gk   = 1;
      bit            pass = 1'b1;
      logic [NL-1:0] pp, pn, dp, dn;
      pp = 8'hAA;
      pn = 8'h55;
      data_p = '0;
      data_n = '0;
      forever begin
         @(negedge clk);
         if (delay_ld != '0) begin
            for (int l = 0; l < NL; l++) if (delay_ld[l]) ldl = l;
            ldt  = int'(delay_wdata);
            offs = 0;
            pass = mask[ldl][ldt];
            goff = SETTLE + 1 + int'($urandom_range(SAMPLE - 1, 0));
            gk   = int'($urandom_range(3, 1));
            if (delay_ld == 8'h04) last_wd2 = delay_wdata;
         end else if (offs < 1000) begin
            offs++;
         end
         dp = NL'($urandom);
         dn = NL'($urandom);
         if (offs > SETTLE && offs <= SETTLE + SAMPLE) begin
            dp[ldl] = pp[ldl];
            dn[ldl] = pn[ldl];
            if (!pass && offs == goff) begin
               if (gk[0]) dp[ldl] = ~dp[ldl];
               if (gk[1]) dn[ldl] = ~dn[ldl];
            end
         end
         data_p = dp;
         data_n = dn;
      end
   end

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("busy_rise", busy, 1'b1);
      chk("done_clear", done, 1'b0);
   endtask

   task automatic run_sweep(input bit spam, output int lat);
      pulse_start();
      lat = 0;
      while (lat < 25000) begin
         @(posedge clk);
         lat++;
         #1;
         if (done) begin
            start = 1'b0;
            break;
         end
         start = (spam && lat < 20000 && lat % 997 == 13);
      end
      start = 1'b0;
      if (!done) begin
         miscompares++;
         $display("FAIL sweep_timeout: done still low after %0d cycles", lat);
      end
   endtask

   initial begin
      int lat;
      reset_n = 1'b0;
      start   = 1'b0;
      for (int l = 0; l < NL; l++) mask[l] = '1;
      repeat (3) @(negedge clk);
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);
      chk("reset_ld", delay_ld, 8'h00);
      chk("reset_tap", lane_tap, 40'h0);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);

      // All taps pass everywhere.
      run_sweep(1'b0, lat);
      chk("lat_allpass", lat, 21008);
      chk("tap_allpass", lane_tap, {8{5'd16}});
      chk("fail_allpass", fail, 8'h00);
      chk("busy_after", busy, 1'b0);

      // Directed windows, glitched lanes, and start spam while busy.
      mask[0] = 32'h0;
      mask[1] = 32'h0;
      mask[2] = 32'h001F_FC00;
      mask[3] = $urandom | 32'h1;
      mask[4] = $urandom | 32'h1;
      mask[5] = 32'h0FF0_0038;
      mask[6] = 32'h0000_F0F0;
      mask[7] = $urandom | 32'h1;
      repeat (5) @(negedge clk);
      run_sweep(1'b1, lat);
      chk("lat_spam", lat, 21008);
      chk("fail_mix", fail, 8'h03);
      chk("tap_lane0", lane_tap[0 +: 5], 5'd0);
      chk("tap_lane1", lane_tap[5 +: 5], 5'd0);
      chk("tap_lane2", lane_tap[10 +: 5], 5'd15);
      chk("tap_lane5", lane_tap[25 +: 5], 5'd24);
      chk("tap_lane6", lane_tap[30 +: 5], 5'd6);
      chk("final_ld2", last_wd2, 5'd15);

      // Reset in the middle of a sweep.
      for (int l = 0; l < NL; l++) mask[l] = $urandom;
      pulse_start();
      repeat (4999) @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_done", done, 1'b0);
      chk("midrst_ld", delay_ld, 8'h00);
      chk("midrst_wdata", delay_wdata, 5'd0);
      chk("midrst_fail", fail, 8'h00);
      chk("midrst_tap", lane_tap, 40'h0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      // Fresh full sweep with random windows after reset.
      for (int l = 0; l < NL; l++) begin
         if ($urandom_range(3, 0) == 0) mask[l] = $urandom & $urandom;
         else mask[l] = $urandom | ($urandom << 3);
      end
      run_sweep(1'b0, lat);
      chk("lat_postrst", lat, 21008);
      repeat (5) @(negedge clk);
      chk("done_held", done, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      miscompares++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
